// File: rtl/chip7458_pkg.sv
// chip7458_pkg: shared vector sizing, FSM state type and the 7458 golden function.
package chip7458_pkg;
  localparam int VEC_W = 10;
  localparam int NUM_VEC = 1024;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
  function automatic logic [1:0] golden(input logic [VEC_W-1:0] v);
    return {(v[6] & v[7]) | (v[8] & v[9]), (v[0] & v[1] & v[2]) | (v[3] & v[4] & v[5])};
  endfunction
endpackage

// File: rtl/chip7458_golden.sv
// chip7458_golden: combinational expected {p2y,p1y} for a vector.
module chip7458_golden
  import chip7458_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [1:0]       exp_y
);
  assign exp_y = golden(vec);
endmodule

// File: rtl/chip7458_exerciser.sv
// chip7458_exerciser: sweeps all 7458 input vectors and checks responses; CHIP7458_EXERCISER_STOP_ON_FAIL_EN stops at first mismatch.
module chip7458_exerciser
  import chip7458_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [9:0]       first_fail_vec,
  output logic             p1a,
  output logic             p1b,
  output logic             p1c,
  output logic             p1d,
  output logic             p1e,
  output logic             p1f,
  output logic             p2a,
  output logic             p2b,
  output logic             p2c,
  output logic             p2d,
  input  logic             p1y,
  input  logic             p2y
);
  localparam int CW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  state_t state, nxt;
  logic [VEC_W-1:0] vec, drv;
  logic [CW-1:0] cnt;
  logic [1:0] exp_y;
  logic mismatch, last, stop, idle_start;
  chip7458_golden u_golden (.vec(vec), .exp_y(exp_y));
  assign mismatch = (p1y != exp_y[0]) | (p2y != exp_y[1]);
  assign last = vec == VEC_W'(NUM_VEC - 1);
`ifdef CHIP7458_EXERCISER_STOP_ON_FAIL_EN
  assign stop = last | mismatch;
`else
  assign stop = last;
`endif
  assign idle_start = start & (state == IDLE | state == DONE);
  assign {p2d, p2c, p2b, p2a, p1f, p1e, p1d, p1c, p1b, p1a} = drv;
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = start ? DRIVE : state;
      DRIVE:      nxt = SETTLE_CYC == 0 ? CHECK : SETTLE;
      SETTLE:     nxt = cnt == '0 ? CHECK : SETTLE;
      CHECK:      nxt = stop ? DONE : DRIVE;
      default:    nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state == DRIVE | state == SETTLE | state == CHECK;
    done = state == DONE;
    pass = done & (err_cnt == '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      vec <= '0;
      drv <= '0;
      cnt <= '0;
      err_cnt <= '0;
      first_fail_vec <= '0;
    end else begin
      if (idle_start) begin
        vec <= '0;
        err_cnt <= '0;
        first_fail_vec <= '0;
      end
      if (state == DRIVE) begin
        drv <= vec;
        cnt <= CW'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
      end
      if (state == SETTLE) cnt <= cnt - 1'b1;
      if (state == CHECK) begin
        if (mismatch) begin
          err_cnt <= &err_cnt ? err_cnt : err_cnt + 1'b1;
          first_fail_vec <= err_cnt == '0 ? vec : first_fail_vec;
        end
        vec <= stop ? vec : vec + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_chip7458_exerciser.sv
// tb_chip7458_exerciser: two exercisers (settle 2 and 0) against a loopback gate with injectable faults.
module tb_chip7458_exerciser;
  logic clk = 0, reset = 1, start = 0;
  logic [1:0] busy, done, pass, p1y, p2y;
  logic [1:0][10:0] err_cnt;
  logic [1:0][9:0] ffv, pins;
  bit f1[1024], f2[1024];
  int stuck1 = -1, stuck2 = -1;
  int nvec = 0, nerr = 0;
  int pre[1025];
  int first = -1;
  int mst[2], cnt[2], mp[2], em[2];
  bit armed = 0;
  always #5 clk = ~clk;

  function automatic bit e1(int v);
    return (v & 7) == 7 || ((v >> 3) & 7) == 7;
  endfunction
  function automatic bit e2(int v);
    return ((v >> 6) & 3) == 3 || ((v >> 8) & 3) == 3;
  endfunction
  function automatic int per(int g);
    return g == 0 ? 4 : 2;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    chip7458_exerciser #(.SETTLE_CYC(g == 0 ? 2 : 0), .ERR_W(11)) u_dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
      .err_cnt(err_cnt[g]), .first_fail_vec(ffv[g]),
      .p1a(pins[g][0]), .p1b(pins[g][1]), .p1c(pins[g][2]), .p1d(pins[g][3]), .p1e(pins[g][4]),
      .p1f(pins[g][5]), .p2a(pins[g][6]), .p2b(pins[g][7]), .p2c(pins[g][8]), .p2d(pins[g][9]),
      .p1y(p1y[g]), .p2y(p2y[g]));
    assign p1y[g] = stuck1 >= 0 ? stuck1[0] : e1(int'(pins[g])) ^ f1[pins[g]];
    assign p2y[g] = stuck2 >= 0 ? stuck2[0] : e2(int'(pins[g])) ^ f2[pins[g]];
  end

  // Bad-vector prefix counts for the current gate configuration.
  task automatic setup();
    bit r1, r2;
    pre[0] = 0;
    first = -1;
    for (int v = 0; v < 1024; v++) begin
      r1 = stuck1 >= 0 ? stuck1[0] : e1(v) ^ f1[v];
      r2 = stuck2 >= 0 ? stuck2[0] : e2(v) ^ f2[v];
      pre[v + 1] = pre[v] + int'(r1 != e1(v) || r2 != e2(v));
      if (pre[v + 1] != pre[v] && first < 0) first = v;
    end
  endtask

  function automatic int endc(int p);
`ifdef CHIP7458_EXERCISER_STOP_ON_FAIL_EN
    if (first >= 0) return (first + 1) * p;
`endif
    return 1024 * p;
  endfunction

  always @(posedge clk)
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        mst[g] = 0; cnt[g] = 0; mp[g] = 0;
      end else if (mst[g] != 1 && start) begin
        mst[g] = 1; cnt[g] = 0; em[g] = endc(per(g));
      end else if (mst[g] == 1) begin
        cnt[g]++;
        mp[g] = (cnt[g] - 1) / per(g);
        if (cnt[g] == em[g]) mst[g] = 2;
      end
    end

  always @(negedge clk)
    if (armed)
      for (int g = 0; g < 2; g++) begin
        int n, ee, ef;
        logic [33:0] act, exp;
        n = mst[g] == 0 ? 0 : cnt[g] / per(g);
        ee = pre[n] > 2047 ? 2047 : pre[n];
        ef = (first >= 0 && n > first) ? first : 0;
        exp = {mst[g] == 1, mst[g] == 2, mst[g] == 2 && ee == 0, 11'(ee), 10'(ef), 10'(mp[g])};
        act = {busy[g], done[g], pass[g], err_cnt[g], ffv[g], pins[g]};
        nvec++;
        if (act !== exp) begin
          nerr++;
          $display("FAIL cycle_chk inst%0d t=%0t got=%h expected=%h", g, $time, act, exp);
        end
      end

  task automatic chk(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2 setup();
    reset = 0;
  endtask

  task automatic sweep(input int kick, output int c0, output int c1);
    int n = 0;
    c0 = -1; c1 = -1;
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
    while ((c0 < 0 || c1 < 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (done[0] && c0 < 0) c0 = n;
      if (done[1] && c1 < 0) c1 = n;
      #1 start = n == kick;
    end
    start = 0;
    if (c0 < 0 || c1 < 0) begin
      nvec++; nerr++;
      $display("FAIL sweep_timeout got=%0d/%0d expected=done", c0, c1);
    end
  endtask

  initial begin
    int c0, c1;
    bit sof;
`ifdef CHIP7458_EXERCISER_STOP_ON_FAIL_EN
    sof = 1;
`else
    sof = 0;
`endif
    repeat (2) @(posedge clk);
    #2 setup();
    armed = 1;
    reset = 0;
    sweep(-1, c0, c1);
    chk("clean_cycles_s2", c0, 4096);
    chk("clean_cycles_s0", c1, 2048);
    chk("clean_err", int'(err_cnt[0]), 0);
    chk("clean_pass", int'(pass[0]), 1);
    chk("clean_ffv", int'(ffv[0]), 0);
    sweep(500, c0, c1);
    chk("kick_cycles_s2", c0, 4096);
    chk("kick_cycles_s0", c1, 2048);
    stuck1 = 0;
    do_reset();
    sweep(-1, c0, c1);
    chk("p1y0_err", int'(err_cnt[0]), sof ? 1 : 240);
    chk("p1y0_ffv", int'(ffv[0]), 7);
    chk("p1y0_pass", int'(pass[0]), 0);
    chk("p1y0_cycles", c0, sof ? 32 : 4096);
    stuck1 = -1; stuck2 = 1;
    do_reset();
    sweep(-1, c0, c1);
    chk("p2y1_err", int'(err_cnt[0]), sof ? 1 : 576);
    chk("p2y1_ffv", int'(ffv[0]), 0);
    chk("p2y1_pass", int'(pass[0]), 0);
    stuck2 = -1;
    do_reset();
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
    repeat (1000) @(posedge clk);
    do_reset();
    chk("abort_done", int'(done[0]), 0);
    sweep(-1, c0, c1);
    chk("restart_cycles", c0, 4096);
    chk("restart_err", int'(err_cnt[0]), 0);
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 1024; v++) begin
        f1[v] = $urandom_range(31) == 0;
        f2[v] = $urandom_range(31) == 0;
      end
      do_reset();
      sweep(-1, c0, c1);
      chk("rand_s0_err", int'(err_cnt[1]), sof && pre[1024] > 0 ? 1 : pre[1024]);
    end
    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
